// File: rtl/rgb_stream_packer_if.sv
// 32-bit AXI4-Stream bundle carrying packed RGB words toward the video DMA.
interface rgb_stream_packer_if;
   logic [31:0] tdata;
   logic [3:0]  tkeep;
   logic        tlast;
   logic        tuser;
   logic        tvalid;
   logic        tready;

   modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
   modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/rgb_stream_packer.sv
// Packs 24-bit RGB pixels into 32-bit AXI4-Stream words (4 pixels -> 3 words),
// little-endian, with tuser on the first word of a frame and tlast at end of line.
module rgb_stream_packer (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic [7:0]                 r,
   input  logic [7:0]                 g,
   input  logic [7:0]                 b,
   input  logic                       valid,
   input  logic                       sof,
   input  logic                       eol,
   output logic                       in_stream_ready,
   rgb_stream_packer_if.master        out_stream,
   output logic                       align_err
);

   typedef enum logic {RUN, FLUSH} mode_e;

   mode_e       mode_q, mode_d;
   logic [1:0]  phase_q, phase_d, eff_phase;
   logic [23:0] carry_q, carry_d, pix;
   logic        pend_sof_q, pend_sof_d;
   logic [31:0] tdata_q, tdata_d;
   logic        tlast_q, tlast_d;
   logic        tuser_q, tuser_d;
   logic        tvalid_q, tvalid_d;
   logic        align_err_q, align_err_d;
   logic        out_free, accept, emit, word_last;
   logic [31:0] word;

   always_ff @(posedge aclk) begin
      if (areset) begin
         mode_q      <= RUN;
         phase_q     <= '0;
         carry_q     <= '0;
         pend_sof_q  <= 1'b0;
         tdata_q     <= '0;
         tlast_q     <= 1'b0;
         tuser_q     <= 1'b0;
         tvalid_q    <= 1'b0;
         align_err_q <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         phase_q     <= phase_d;
         carry_q     <= carry_d;
         pend_sof_q  <= pend_sof_d;
         tdata_q     <= tdata_d;
         tlast_q     <= tlast_d;
         tuser_q     <= tuser_d;
         tvalid_q    <= tvalid_d;
         align_err_q <= align_err_d;
      end
   end

   always_comb begin
      pix             = {r, g, b};
      out_free        = !tvalid_q || out_stream.tready;
      in_stream_ready = !areset && (mode_q == RUN) && out_free;
      accept          = valid && in_stream_ready;
      // sof restarts packing: the pixel is handled as phase 0 whatever the counter says
      eff_phase       = sof ? 2'd0 : phase_q;

      mode_d      = mode_q;
      phase_d     = phase_q;
      carry_d     = carry_q;
      pend_sof_d  = pend_sof_q;
      tdata_d     = tdata_q;
      tlast_d     = tlast_q;
      tuser_d     = tuser_q;
      tvalid_d    = out_free ? 1'b0 : tvalid_q;
      align_err_d = 1'b0;
      emit        = 1'b0;
      word        = '0;
      word_last   = 1'b0;

      if (mode_q == FLUSH) begin
         // carry_q holds the leftover bytes already zero-extended
         if (out_free) begin
            tdata_d    = {8'h00, carry_q};
            tlast_d    = 1'b1;
            tuser_d    = pend_sof_q;
            tvalid_d   = 1'b1;
            pend_sof_d = 1'b0;
            carry_d    = '0;
            mode_d     = RUN;
         end
      end else if (accept) begin
         align_err_d = sof && (phase_q != 2'd0);
         case (eff_phase)
            2'd0: begin
               carry_d = pix;
               if (eol) begin
                  emit      = 1'b1;
                  word      = {8'h00, pix};
                  word_last = 1'b1;
                  phase_d   = 2'd0;
               end else begin
                  phase_d = 2'd1;
               end
            end
            2'd1: begin
               emit    = 1'b1;
               word    = {pix[7:0], carry_q};
               carry_d = {8'h00, pix[23:8]};
               phase_d = eol ? 2'd0 : 2'd2;
               if (eol) mode_d = FLUSH;
            end
            2'd2: begin
               emit    = 1'b1;
               word    = {pix[15:0], carry_q[15:0]};
               carry_d = {16'h0000, pix[23:16]};
               phase_d = eol ? 2'd0 : 2'd3;
               if (eol) mode_d = FLUSH;
            end
            2'd3: begin
               emit      = 1'b1;
               word      = {pix, carry_q[7:0]};
               word_last = eol;
               phase_d   = 2'd0;
            end
         endcase

         if (emit) begin
            tdata_d    = word;
            tlast_d    = word_last;
            tuser_d    = pend_sof_q || sof;
            tvalid_d   = 1'b1;
            pend_sof_d = 1'b0;
         end else if (sof) begin
            pend_sof_d = 1'b1;
         end
      end
   end

   assign out_stream.tdata  = tdata_q;
   assign out_stream.tkeep  = '1;
   assign out_stream.tlast  = tlast_q;
   assign out_stream.tuser  = tuser_q;
   assign out_stream.tvalid = tvalid_q;
   assign align_err         = align_err_q;

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Directed and small-frame scoreboard bench for rgb_stream_packer.
module tb_rgb_stream_packer;

   logic       aclk;
   logic       areset;
   logic [7:0] r, g, b;
   logic       valid, sof, eol;
   logic       in_stream_ready;
   logic       align_err;
   logic       tready_dir, rnd_bit, rand_mode;

   rgb_stream_packer_if out_if ();

   assign out_if.tready = rand_mode ? rnd_bit : tready_dir;

   rgb_stream_packer dut (
      .aclk            (aclk),
      .areset          (areset),
      .r               (r),
      .g               (g),
      .b               (b),
      .valid           (valid),
      .sof             (sof),
      .eol             (eol),
      .in_stream_ready (in_stream_ready),
      .out_stream      (out_if),
      .align_err       (align_err)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   int          vectors, miscompares;
   int          words_seen, last_seen, user_seen, user_idx;
   logic [33:0] sb[$];
   logic [7:0]  mq[$];
   logic        mpend;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic u, input logic l, input logic [31:0] d);
      sb.push_back({u, l, d});
   endtask

   // Reference packing: a byte FIFO per line, words drained 4 bytes at a time.
   task automatic model_pixel(input logic [23:0] p, input logic s, input logic e);
      logic [31:0] w;
      if (s) begin
         mq.delete();
         mpend = 1'b1;
      end
      mq.push_back(p[7:0]);
      mq.push_back(p[15:8]);
      mq.push_back(p[23:16]);
      if (mq.size() >= 4) begin
         w = {mq[3], mq[2], mq[1], mq[0]};
         for (int i = 0; i < 4; i++) void'(mq.pop_front());
         push_exp(mpend, e && (mq.size() == 0), w);
         mpend = 1'b0;
      end
      if (e && mq.size() != 0) begin
         w = '0;
         for (int i = 0; i < mq.size(); i++) w[8*i +: 8] = mq[i];
         mq.delete();
         push_exp(mpend, 1'b1, w);
         mpend = 1'b0;
      end
   endtask

   task automatic send(input logic [23:0] p, input logic s, input logic e, input logic exp_align);
      int n;
      r = p[23:16]; g = p[15:8]; b = p[7:0];
      sof = s; eol = e; valid = 1'b1;
      n = 0;
      forever begin
         @(negedge aclk);
         if (in_stream_ready) break;
         n++;
         if (n > 200) break;
      end
      if (n > 200) begin
         vectors++;
         miscompares++;
         $error("FAIL send_timeout observed=ready_low expected=ready_high");
         valid = 1'b0;
      end else begin
         @(posedge aclk);
         #1;
         check("align_err", align_err, exp_align);
      end
   endtask

   task automatic idle();
      valid = 1'b0; sof = 1'b0; eol = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge aclk);
         n++;
      end
      check("drain_pending", sb.size(), 0);
      @(posedge aclk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tvalid"}, out_if.tvalid, 1'b0);
      check({tag, "_tdata"}, out_if.tdata, 32'h0);
      check({tag, "_tlast"}, out_if.tlast, 1'b0);
      check({tag, "_tuser"}, out_if.tuser, 1'b0);
      check({tag, "_align"}, align_err, 1'b0);
      check({tag, "_ready"}, in_stream_ready, 1'b0);
   endtask

   task automatic run_frame(input int w, input int h, input int exp_words);
      int w0, l0, u0;
      logic [7:0] xb, yb;
      w0 = words_seen; l0 = last_seen; u0 = user_seen;
      rand_mode = 1'b1;
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            xb = 8'(x); yb = 8'(y);
            model_pixel({yb, xb, xb ^ (yb << 3)}, (x == 0) && (y == 0), x == w - 1);
            send({yb, xb, xb ^ (yb << 3)}, (x == 0) && (y == 0), x == w - 1, 1'b0);
         end
      end
      idle();
      drain();
      rand_mode = 1'b0;
      check("frame_words", words_seen - w0, exp_words);
      check("frame_tlast", last_seen - l0, h);
      check("frame_tuser", user_seen - u0, 1);
      check("frame_tuser_idx", user_idx, w0);
   endtask

   initial begin
      logic [33:0] e;
      vectors = 0; miscompares = 0;
      words_seen = 0; last_seen = 0; user_seen = 0; user_idx = -1;
      mpend = 1'b0;
      areset = 1'b1; valid = 1'b0; sof = 1'b0; eol = 1'b0;
      r = '0; g = '0; b = '0;
      tready_dir = 1'b1; rnd_bit = 1'b1; rand_mode = 1'b0;

      fork
         forever @(posedge aclk) rnd_bit <= 1'($urandom_range(0, 1));
         forever begin
            @(negedge aclk);
            if (!areset && out_if.tvalid && out_if.tready) begin
               if (sb.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $error("FAIL unexpected_word observed=%0h expected=none", out_if.tdata);
               end else begin
                  e = sb.pop_front();
                  check("word_user_last_data", {out_if.tuser, out_if.tlast, out_if.tdata}, e);
                  check("tkeep", out_if.tkeep, 4'hF);
               end
               words_seen++;
               if (out_if.tlast) last_seen++;
               if (out_if.tuser) begin
                  user_seen++;
                  user_idx = words_seen - 1;
               end
            end
         end
      join_none

      // power-on reset
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check_reset_outputs("por");
      @(posedge aclk); #1;
      areset = 1'b0;
      @(negedge aclk);
      check("ready_after_reset", in_stream_ready, 1'b1);
      @(posedge aclk); #1;

      // basic packing
      push_exp(1'b1, 1'b0, 32'h66112233);
      push_exp(1'b0, 1'b0, 32'h88994455);
      push_exp(1'b0, 1'b1, 32'hAABBCC77);
      send(24'h112233, 1'b1, 1'b0, 1'b0);
      send(24'h445566, 1'b0, 1'b0, 1'b0);
      send(24'h778899, 1'b0, 1'b0, 1'b0);
      send(24'hAABBCC, 1'b0, 1'b1, 1'b0);
      idle();
      drain();

      // backpressure: first word must hold while tready is low
      tready_dir = 1'b0;
      push_exp(1'b1, 1'b0, 32'h66112233);
      push_exp(1'b0, 1'b0, 32'h88994455);
      push_exp(1'b0, 1'b1, 32'hAABBCC77);
      send(24'h112233, 1'b1, 1'b0, 1'b0);
      send(24'h445566, 1'b0, 1'b0, 1'b0);
      idle();
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         check("bp_tvalid", out_if.tvalid, 1'b1);
         check("bp_tdata", out_if.tdata, 32'h66112233);
         check("bp_tuser", out_if.tuser, 1'b1);
         check("bp_ready", in_stream_ready, 1'b0);
      end
      @(posedge aclk); #1;
      tready_dir = 1'b1;
      send(24'h778899, 1'b0, 1'b0, 1'b0);
      send(24'hAABBCC, 1'b0, 1'b1, 1'b0);
      idle();
      drain();

      // 2-pixel line: flush costs one ready-low cycle
      push_exp(1'b1, 1'b0, 32'h66112233);
      push_exp(1'b0, 1'b1, 32'h00004455);
      send(24'h112233, 1'b1, 1'b0, 1'b0);
      send(24'h445566, 1'b0, 1'b1, 1'b0);
      idle();
      @(negedge aclk);
      check("flush_ready_low", in_stream_ready, 1'b0);
      @(negedge aclk);
      check("flush_ready_back", in_stream_ready, 1'b1);
      @(posedge aclk); #1;
      drain();

      // 1-pixel line with sof
      push_exp(1'b1, 1'b1, 32'h00112233);
      send(24'h112233, 1'b1, 1'b1, 1'b0);
      idle();
      drain();

      // misaligned sof at phase 2
      push_exp(1'b0, 1'b0, 32'h66112233);
      push_exp(1'b1, 1'b0, 32'hCC778899);
      push_exp(1'b0, 1'b0, 32'h0203AABB);
      push_exp(1'b0, 1'b1, 32'h00000001);
      send(24'h112233, 1'b0, 1'b0, 1'b0);
      send(24'h445566, 1'b0, 1'b0, 1'b0);
      send(24'h778899, 1'b1, 1'b0, 1'b1);
      send(24'hAABBCC, 1'b0, 1'b0, 1'b0);
      send(24'h010203, 1'b0, 1'b1, 1'b0);
      idle();
      drain();

      // reset mid-line with a held word
      tready_dir = 1'b0;
      send(24'h112233, 1'b1, 1'b0, 1'b0);
      send(24'h445566, 1'b0, 1'b0, 1'b0);
      idle();
      areset = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      check_reset_outputs("midreset");
      @(posedge aclk); #1;
      areset = 1'b0;
      tready_dir = 1'b1;
      push_exp(1'b1, 1'b0, 32'h66112233);
      push_exp(1'b0, 1'b0, 32'h88994455);
      push_exp(1'b0, 1'b1, 32'hAABBCC77);
      send(24'h112233, 1'b1, 1'b0, 1'b0);
      send(24'h445566, 1'b0, 1'b0, 1'b0);
      send(24'h778899, 1'b0, 1'b0, 1'b0);
      send(24'hAABBCC, 1'b0, 1'b1, 1'b0);
      idle();
      drain();

      // reduced frames with random tready
      run_frame(64, 16, 768);
      run_frame(6, 4, 20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
